// File: rtl/cacheline_adaptor_if.sv
// cacheline_adaptor_if
//   Bundles both sides of the cacheline adaptor into one interface.
//   Cache side : line_i, address_i, read_i, write_i  -> adaptor
//                line_o, resp_o                      <- adaptor
//   Memory side: burst_i, resp_i                     -> adaptor
//                burst_o, address_o, read_o, write_o <- adaptor
//   Modports:
//     slave  - the adaptor's view (drives line_o/resp_o/burst_o/address_o/read_o/write_o)
//     master - the environment's view (cache + memory model together)
//
// Handshake: the cache holds read_i or write_i high until it sees the
// one-cycle resp_o pulse. On the memory side, read_o/write_o stay high for the
// whole burst and every cycle with resp_i high moves exactly one beat; a cycle
// with resp_i low is a stall that moves nothing.
interface cacheline_adaptor_if #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
);
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//   Turns whole-line cache read/write requests into BEATS-beat bursts of
//   BURST_W bits on the memory port and reassembles read bursts into a line.
//   One transaction in flight at a time; the only storage is one line buffer.
//
//   Ports:
//     clk      - clock
//     rst      - synchronous, active-high reset
//     bus      - cacheline_adaptor_if.slave (cache side and memory side)
//     state_o  - current FSM state, for debug/observation only
//
//   Beat k of a line is line[BURST_W*k +: BURST_W]; beat 0 goes first.
//   Memory address is the line address with the 5 byte-offset bits cleared.
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  cacheline_adaptor_if.slave        bus,
  output logic [1:0]                state_o
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  generate
    if ((LINE_W % BURST_W) != 0 || BEATS < 2) begin : g_bad_params
      $error("cacheline_adaptor: LINE_W must be a multiple (>=2) of BURST_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [LINE_W-1:0]  line_buf;
  logic [31:0]        addr_q;
  logic               read_q;
  logic               write_q;
  logic               resp_q;

  // Single FSM process; read_o/write_o/resp_o are registered alongside the
  // state so they change exactly on the state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      line_buf <= '0;
      addr_q   <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      resp_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Write wins if the cache ever raises both at once.
          if (bus.write_i) begin
            addr_q   <= bus.address_i;
            line_buf <= bus.line_i;
            cnt      <= '0;
            write_q  <= 1'b1;
            state    <= S_WRITE;
          end else if (bus.read_i) begin
            addr_q <= bus.address_i;
            cnt    <= '0;
            read_q <= 1'b1;
            state  <= S_READ;
          end
        end

        S_READ: begin
          if (bus.resp_i) begin
            line_buf[BURST_W*cnt +: BURST_W] <= bus.burst_i;
            if (cnt == LAST_BEAT) begin
              cnt    <= '0;
              read_q <= 1'b0;
              resp_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        S_WRITE: begin
          if (bus.resp_i) begin
            if (cnt == LAST_BEAT) begin
              cnt     <= '0;
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              state   <= S_DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        S_DONE: begin
          // resp_o is a single-cycle pulse; requests seen here are ignored.
          resp_q <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          state   <= S_IDLE;
          cnt     <= '0;
          read_q  <= 1'b0;
          write_q <= 1'b0;
          resp_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.read_o    = read_q;
  assign bus.write_o   = write_q;
  assign bus.resp_o    = resp_q;
  assign bus.line_o    = line_buf;
  assign bus.address_o = (read_q || write_q) ? {addr_q[31:5], 5'b0} : 32'd0;
  // Current write beat follows cnt directly, so it holds through stalls and
  // advances the cycle after each accepted beat.
  assign bus.burst_o   = (state == S_WRITE) ? line_buf[BURST_W*cnt +: BURST_W]
                                            : '0;
  assign state_o       = state;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor
//   Self-checking bench for cacheline_adaptor. The driver tasks act as cache
//   and memory at transaction level and publish, for every cycle, what the
//   outputs must be; one negedge process compares them against the DUT.
module tb_cacheline_adaptor;
  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = LINE_W / BURST_W;

  typedef logic [LINE_W-1:0] wide_t;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_o;
  always #5 clk = ~clk;

  cacheline_adaptor_if #(.LINE_W(LINE_W), .BURST_W(BURST_W)) bus ();

  cacheline_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  logic               chk_en = 1'b0;
  logic               exp_read, exp_write, exp_resp;
  logic [31:0]        exp_addr;
  logic [BURST_W-1:0] exp_burst;
  wide_t              exp_line;

  // The line as the cache would see it: beat k at bits [BURST_W*k +: BURST_W].
  logic [BURST_W-1:0] mdl_beat [BEATS];
  logic [BURST_W-1:0] burst_log [64];

  task automatic check(string name, wide_t act, wide_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("read_o",    wide_t'(bus.read_o),    wide_t'(exp_read));
      check("write_o",   wide_t'(bus.write_o),   wide_t'(exp_write));
      check("resp_o",    wide_t'(bus.resp_o),    wide_t'(exp_resp));
      check("address_o", wide_t'(bus.address_o), wide_t'(exp_addr));
      check("line_o",    bus.line_o,             exp_line);
      if (exp_write) check("burst_o", wide_t'(bus.burst_o), wide_t'(exp_burst));
    end
  end

  // ---------------- model helpers ----------------
  function automatic wide_t mdl_line();
    wide_t l;
    for (int k = 0; k < BEATS; k++) l[k*BURST_W +: BURST_W] = mdl_beat[k];
    return l;
  endfunction

  function automatic wide_t rand_line();
    wide_t l;
    for (int k = 0; k < LINE_W/32; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [BURST_W-1:0] rand_beat();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [31:0] line_addr(logic [31:0] a);
    return a & 32'hFFFF_FFE0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_read  = 1'b0;
    exp_write = 1'b0;
    exp_resp  = 1'b0;
    exp_addr  = 32'd0;
    exp_burst = '0;
    exp_line  = mdl_line();
  endtask

  // ---------------- driver tasks ----------------
  // Idle cycles with noise on the memory side: resp_i must be ignored.
  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) begin
      bus.read_i    = 1'b0;
      bus.write_i   = 1'b0;
      bus.resp_i    = 1'($urandom_range(0, 1));
      bus.burst_i   = rand_beat();
      bus.address_i = $urandom;
      bus.line_i    = rand_line();
      set_idle_exp();
      step();
    end
  endtask

  // Decide resp_i for in-burst cycle cyc (1-based). A non-zero mask gives a
  // fixed pattern; otherwise random with a cap on consecutive stalls.
  function automatic logic pick_resp(logic [31:0] mask, int cyc, int stall);
    if (mask != 32'd0) return mask[cyc-1];
    if (stall >= 6) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  // Completion cycle: resp_o pulse; request lines are wiggled and must be ignored.
  task automatic done_cycle();
    bus.read_i  = 1'($urandom_range(0, 1));
    bus.write_i = 1'($urandom_range(0, 1));
    bus.resp_i  = 1'($urandom_range(0, 1));
    bus.burst_i = rand_beat();
    set_idle_exp();
    exp_resp = 1'b1;
    step();
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input wide_t data,
                         input logic [31:0] mask,
                         output int done_cyc, output logic [31:0] addr_seen);
    int beats = 0;
    int stall = 0;
    int cyc;
    logic r;
    bus.read_i    = 1'b1;
    bus.write_i   = 1'b0;
    bus.address_i = a;
    bus.resp_i    = 1'($urandom_range(0, 1));
    bus.burst_i   = rand_beat();
    bus.line_i    = rand_line();
    set_idle_exp();
    step();
    bus.read_i    = 1'b0;
    bus.address_i = $urandom;
    addr_seen     = bus.address_o;
    cyc = 1;
    while (beats < BEATS && cyc < 60) begin
      r = pick_resp(mask, cyc, stall);
      bus.resp_i  = r;
      bus.burst_i = r ? data[beats*BURST_W +: BURST_W] : rand_beat();
      set_idle_exp();
      exp_read = 1'b1;
      exp_addr = line_addr(a);
      step();
      if (r) begin
        mdl_beat[beats] = data[beats*BURST_W +: BURST_W];
        beats++;
        stall = 0;
      end else begin
        stall++;
      end
      cyc++;
    end
    done_cyc = cyc;
    done_cycle();
  endtask

  task automatic do_write(input logic [31:0] a, input wide_t line,
                          input logic [31:0] mask, input logic also_read,
                          output int done_cyc);
    int beats = 0;
    int stall = 0;
    int cyc;
    logic r;
    bus.write_i   = 1'b1;
    bus.read_i    = also_read;
    bus.address_i = a;
    bus.line_i    = line;
    bus.resp_i    = 1'($urandom_range(0, 1));
    bus.burst_i   = rand_beat();
    set_idle_exp();
    step();
    bus.write_i   = 1'b0;
    bus.read_i    = 1'b0;
    bus.line_i    = rand_line();
    bus.address_i = $urandom;
    for (int k = 0; k < BEATS; k++) mdl_beat[k] = line[k*BURST_W +: BURST_W];
    cyc = 1;
    while (beats < BEATS && cyc < 60) begin
      r = pick_resp(mask, cyc, stall);
      bus.resp_i  = r;
      bus.burst_i = rand_beat();
      set_idle_exp();
      exp_write = 1'b1;
      exp_addr  = line_addr(a);
      exp_burst = line[beats*BURST_W +: BURST_W];
      burst_log[cyc] = exp_burst;
      step();
      if (r) begin
        beats++;
        stall = 0;
      end else begin
        stall++;
      end
      cyc++;
    end
    done_cyc = cyc;
    done_cycle();
  endtask

  // Read that is cut off by reset after two beats.
  task automatic do_read_reset(input logic [31:0] a, input wide_t data);
    bus.read_i    = 1'b1;
    bus.write_i   = 1'b0;
    bus.address_i = a;
    bus.resp_i    = 1'b0;
    set_idle_exp();
    step();
    bus.read_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = data[k*BURST_W +: BURST_W];
      set_idle_exp();
      exp_read = 1'b1;
      exp_addr = line_addr(a);
      step();
      mdl_beat[k] = data[k*BURST_W +: BURST_W];
    end
    rst         = 1'b1;
    bus.resp_i  = 1'b1;
    bus.burst_i = data[2*BURST_W +: BURST_W];
    set_idle_exp();
    exp_read = 1'b1;
    exp_addr = line_addr(a);
    step();
    rst = 1'b0;
    for (int k = 0; k < BEATS; k++) mdl_beat[k] = '0;
  endtask

  // ---------------- main sequence ----------------
  int          dc;
  logic [31:0] aseen;
  wide_t       lit_rd, lit_wr;

  initial begin
    rst           = 1'b1;
    bus.line_i    = '0;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    for (int k = 0; k < BEATS; k++) mdl_beat[k] = '0;
    set_idle_exp();
    step();
    chk_en = 1'b1;
    bus.resp_i = 1'b1;
    step();
    rst = 1'b0;
    idle_cycles(2);

    // Directed read, no stalls.
    lit_rd = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    do_read(32'h0000_1234, lit_rd, 32'h0000_000F, dc, aseen);
    check("lit_read_addr", wide_t'(aseen), wide_t'(32'h0000_1220));
    check("lit_read_done_cycle", wide_t'(dc), wide_t'(5));
    check("lit_read_line", bus.line_o,
          256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

    // Back-to-back write with stalls: beats accepted at cycles 2, 3, 6, 7.
    lit_wr = {64'hD3D3_0000_0000_D3D3, 64'hD2D2_0000_0000_D2D2,
              64'hD1D1_0000_0000_D1D1, 64'hD0D0_0000_0000_D0D0};
    do_write(32'hABCD_EF7F, lit_wr, 32'h0000_0066, 1'b0, dc);
    check("lit_write_done_cycle", wide_t'(dc), wide_t'(8));
    check("lit_burst_c2", wide_t'(burst_log[2]), wide_t'(64'hD0D0_0000_0000_D0D0));
    check("lit_burst_c3", wide_t'(burst_log[3]), wide_t'(64'hD1D1_0000_0000_D1D1));
    check("lit_burst_c4", wide_t'(burst_log[4]), wide_t'(64'hD2D2_0000_0000_D2D2));
    check("lit_burst_c6", wide_t'(burst_log[6]), wide_t'(64'hD2D2_0000_0000_D2D2));
    check("lit_burst_c7", wide_t'(burst_log[7]), wide_t'(64'hD3D3_0000_0000_D3D3));
    check("lit_write_line", bus.line_o, lit_wr);

    // Spurious resp_i while idle.
    idle_cycles(3);

    // read_i and write_i together: write path only.
    do_write($urandom, rand_line(), 32'd0, 1'b1, dc);

    // Reset in the middle of a read, then a clean read.
    do_read_reset(32'h0000_4000, rand_line());
    idle_cycles(1);
    check("lit_line_after_reset", bus.line_o, wide_t'(0));
    do_read($urandom, rand_line(), 32'd0, dc, aseen);

    // Randomised traffic.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_read($urandom, rand_line(), 32'd0, dc, aseen);
      else
        do_write($urandom, rand_line(), 32'd0, 1'($urandom_range(0, 1)), dc);
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(2);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Converts the cache's whole-line physical-memory requests into 4-beat 64-bit bursts on the main-memory port, and reassembles read bursts into a full line. Sits directly downstream of the cache controller's physical-memory port (its pmem_read / pmem_write / pmem_resp handshake) and upstream of the burst-mode memory model. Only one transaction is outstanding at a time; no buffering beyond one line.

## Interface
Parameters:
- LINE_W, 256, cache line width in bits
- BURST_W, 64, memory beat width; BEATS = LINE_W/BURST_W = 4, exact division required

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- line_i  in  LINE_W  write line from cache
- line_o  out  LINE_W  assembled read line
- address_i  in  32  line address from cache
- read_i  in  1  cache line read request
- write_i  in  1  cache line write request
- resp_o  out  1  one-cycle completion pulse to cache
- burst_i  in  BURST_W  read beat from memory
- burst_o  out  BURST_W  write beat to memory
- address_o  out  32  burst base address, {addr[31:5], 5'b0}
- read_o  out  1  memory burst read request
- write_o  out  1  memory burst write request
- resp_i  in  1  memory beat valid/accepted

## Operation
- States: IDLE, READ, WRITE, DONE. 2-bit beat counter cnt; line buffer buf[LINE_W-1:0]; address register addr.
- IDLE: if write_i, latch addr <= address_i, buf <= line_i, cnt <= 0, go WRITE. Else if read_i, latch addr, cnt <= 0, go READ. write_i has priority when both high (illegal from cache, but defined). resp_i ignored.
- READ: read_o = 1. Each cycle with resp_i = 1: buf[BURST_W*cnt +: BURST_W] <= burst_i, cnt++. On beat with cnt == 3, go DONE. Cycles with resp_i = 0 are stalls: no capture, no count change.
- WRITE: write_o = 1; burst_o = buf[BURST_W*cnt +: BURST_W] combinationally. Each resp_i = 1 counts an accepted beat, cnt++; beat cnt == 3 accepted -> DONE.
- DONE: resp_o = 1 for exactly this cycle; read_o = write_o = 0; next state IDLE unconditionally. read_i/write_i ignored in DONE.
- line_o = buf at all times; valid from the DONE cycle of a read until the next transaction starts overwriting buf.
- address_o = {addr[31:5], 5'b0} whenever read_o or write_o is high; 0 otherwise.
- cnt wraps 3 -> 0 only by leaving the state; no beat beyond the fourth is ever captured.

## Timing
- Reset (any state, mid-burst included): state IDLE, cnt 0, buf 0, addr 0; outputs resp_o 0, read_o 0, write_o 0, address_o 0, burst_o 0, line_o 0. Partially received/sent line discarded; memory sees request drop next cycle.
- Request sampled at edge ending cycle 0 in IDLE; read_o/write_o high from cycle 1.
- Beats counted on any cycle in READ/WRITE, including cycle 1. Minimum latency with back-to-back resp_i at cycles 1-4: resp_o high at cycle 5, read_o/write_o low from cycle 5.
- Cache must deassert read_i/write_i by the cycle after resp_o; a request still high in the following IDLE starts a new transaction.
- burst_o changes on the cycle after each accepted beat; held stable during stalls.

## Test plan
- Read, no stalls: read_i, address_i = 0x0000_1234; resp_i cycles 1-4 with burst_i 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o = 0x0000_1220, read_o high cycles 1-4, resp_o at cycle 5 only, line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write with stalls: line_i = {D3,D2,D1,D0}, resp_i at cycles 2, 3, 6, 7 -> burst_o = D0 through cycle 2, D1 cycle 3, D2 cycles 4-6, D3 cycle 7; resp_o at cycle 8; write_o low in cycle 8.
- Simultaneous read_i & write_i in IDLE -> WRITE path taken, read_o never asserted.
- Reset after 2 read beats -> next cycle read_o 0, resp_o 0, line_o 0; subsequent read completes normally with correct data, no stale beats.
- Spurious resp_i in IDLE and in DONE -> no state change, no capture, no extra resp_o.
- Back-to-back: read completes, cache issues write the cycle after resp_o -> write_o high 2 cycles after resp_o, both transactions correct.
